// File: rtl/vx_writeback_sched_pkg.sv
// Shared writeback-scheduler types: FSM state enum and beat payload layout.
package VX_gpu_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wb_sched_state_e;

  localparam int WB_WIS_W   = 2;
  localparam int WB_RD_W    = 5;
  localparam int WB_TMASK_W = 4;
  localparam int WB_UUID_W  = 21;
  localparam int WB_DATA_W  = 32;

  // 64-bit default beat; eop travels beside it, not inside it
  typedef struct packed {
    logic [WB_WIS_W-1:0]   wis;
    logic [WB_RD_W-1:0]    rd;
    logic [WB_TMASK_W-1:0] tmask;
    logic [WB_UUID_W-1:0]  uuid;
    logic [WB_DATA_W-1:0]  data;
  } wb_beat_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_writeback_sched_arb.sv
// Combinational round-robin grant: first asserted request at or after ptr_i.
module VX_rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [SELW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (!valid_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = SELW'(k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_writeback_sched.sv
// Writeback port scheduler: round-robin, locks onto a multi-beat packet.
// Optional perf counters enabled by WB_SCHED_PERF_EN.
module vx_writeback_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64
`ifdef WB_SCHED_PERF_EN
  ,
  parameter int PERF_CTR_BITS = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  output logic [DATAW-1:0]          wb_data,
  output logic                      wb_eop,
  output logic [sel_width(NUM_REQS)-1:0] wb_sel
`ifdef WB_SCHED_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]  perf_conflicts,
  output logic [PERF_CTR_BITS-1:0]  perf_lock_cycles
`endif
);

  localparam int SELW = sel_width(NUM_REQS);

  wb_sched_state_e state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] rr_q, rr_d;

  logic [NUM_REQS-1:0] gnt;
  logic [SELW-1:0]     gnt_idx;
  logic                gnt_any;

  logic [NUM_REQS-1:0] ready;
  logic [SELW-1:0]     sel;
  logic                fire;
  logic                eop_sel;
  logic [DATAW-1:0]    data_sel;

  logic             wb_valid_q;
  logic [DATAW-1:0] wb_data_q;
  logic             wb_eop_q;
  logic [SELW-1:0]  wb_sel_q;

  function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
    if (idx == SELW'(NUM_REQS - 1)) return '0;
    return idx + 1'b1;
  endfunction

  VX_rr_arbiter #(
    .N    (NUM_REQS),
    .SELW (SELW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_any)
  );

  assign eop_sel  = req_eop[sel];
  assign data_sel = req_data[int'(sel)*DATAW +: DATAW];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    ready   = '0;
    sel     = gnt_idx;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = gnt;
        fire  = gnt_any;
        if (gnt_any) begin
          if (eop_sel) begin
            rr_d = next_idx(gnt_idx);
          end else begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        sel        = owner_q;
        ready[sel] = req_valid[sel];
        fire       = req_valid[sel];
        if (fire && eop_sel) begin
          state_d = IDLE;
          rr_d    = next_idx(owner_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ready is forced low while reset is held, independent of the inputs
  assign req_ready = ready & {NUM_REQS{reset}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_eop_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_sel_q   <= '0;
    end else begin
      wb_valid_q <= fire;
      wb_eop_q   <= fire & eop_sel;
      if (fire) begin
        wb_data_q <= data_sel;
        wb_sel_q  <= sel;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_eop   = wb_eop_q;
  assign wb_sel   = wb_sel_q;

`ifdef WB_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] conf_q, conf_d;
  logic [PERF_CTR_BITS-1:0] lock_q, lock_d;

  always_comb begin
    conf_d = conf_q;
    lock_d = lock_q;
    if (|(req_valid & ~ready)) conf_d = conf_q + 1'b1;
    if (state_q == LOCKED)     lock_d = lock_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_q <= '0;
      lock_q <= '0;
    end else begin
      conf_q <= conf_d;
      lock_q <= lock_d;
    end
  end

  assign perf_conflicts   = conf_q;
  assign perf_lock_cycles = lock_q;
`endif

endmodule
